// File: rtl/rv32i_pipeline_ctrl_pkg.sv
// Shared constants and types for the RV32i pipeline control unit.
package rv32i_pipeline_ctrl_pkg;

   localparam int STG_IF   = 0;
   localparam int STG_DEC  = 1;
   localparam int STG_EXEC = 2;
   localparam int STG_MEM  = 3;
   localparam int STG_WB   = 4;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic {CTRL_RUN, CTRL_FLUSH} ctrl_state_t;

endpackage

// File: rtl/rv32i_pipeline_ctrl_fetch_tracker.sv
// Fetch tracker: counts issued-but-unanswered imem reads and kills wrong-path
// responses after a redirect using an exact kill count.
module rv32i_fetch_tracker
   import rv32i_pipeline_ctrl_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic issue_i,
   input  logic imem_valid_i,
   input  logic redirect_i,
   output logic busy_o,
   output logic free_o,
   output logic inst_kill_o
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

   ctrl_state_t   state_q, state_d;
   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [OW-1:0] kill_cnt_q, kill_cnt_d;
   logic [OW-1:0] remaining;
   logic          resp_ok;
   logic          proto_err;

   always_comb begin
      resp_ok       = imem_valid_i & (outstanding_q != '0);
      proto_err     = imem_valid_i & (outstanding_q == '0);
      remaining     = outstanding_q - OW'(resp_ok);
      outstanding_d = proto_err ? '0 : remaining + OW'(issue_i);
      state_d       = state_q;
      kill_cnt_d    = kill_cnt_q;
      // A redirect turns every fetch still in flight into wrong-path, in either state.
      if (redirect_i) begin
         if (remaining != '0) begin
            state_d    = CTRL_FLUSH;
            kill_cnt_d = remaining;
         end else begin
            state_d    = CTRL_RUN;
            kill_cnt_d = '0;
         end
      end else if (state_q == CTRL_FLUSH && imem_valid_i) begin
         kill_cnt_d = kill_cnt_q - OW'(1);
         if (kill_cnt_q == OW'(1)) state_d = CTRL_RUN;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= CTRL_RUN;
         outstanding_q <= '0;
         kill_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         kill_cnt_q    <= kill_cnt_d;
      end
   end

   assign busy_o      = (outstanding_q != '0) | (state_q == CTRL_FLUSH);
   assign free_o      = (outstanding_q < MAX_OUT) | ((outstanding_q == MAX_OUT) & imem_valid_i);
   assign inst_kill_o = ~reset_i & imem_valid_i & ((state_q == CTRL_FLUSH) | (outstanding_q == '0));

endmodule

// File: rtl/rv32i_pipeline_ctrl.sv
// Central stall/flush/fetch control for the RV32i pipeline.
// Define RV32I_PIPELINE_CTRL_PERF_EN to add the stall/kill performance counters.
module rv32i_pipeline_ctrl
   import rv32i_pipeline_ctrl_pkg::*;
#(
   parameter int NB_STAGES       = 5,
   parameter int EXEC_STAGE      = 2,
   parameter int MEM_STAGE       = 3,
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   output logic                 imem_re_o,
   input  logic                 imem_valid_i,
   output logic                 inst_kill_o,
   input  logic                 hazard_i,
   input  logic                 dmem_req_i,
   input  logic                 dmem_valid_i,
   input  logic                 redirect_i,
   output logic [NB_STAGES-1:0] stall_o,
   output logic [NB_STAGES-1:0] flush_o
`ifdef RV32I_PIPELINE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]     stall_cycles_o,
   output logic [CNT_W-1:0]     flush_cycles_o
`endif
);

   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7 || CNT_W < 1) begin : g_param_check
      $error("rv32i_pipeline_ctrl: illegal MAX_OUTSTANDING or CNT_W");
   end

   logic mem_wait;
   logic redirect_acc;
   logic fetch_wait;
   logic fetch_busy;
   logic fetch_free;

   assign mem_wait     = dmem_req_i & ~dmem_valid_i;
   assign redirect_acc = redirect_i & ~mem_wait;
   assign fetch_wait   = fetch_busy & ~imem_valid_i;

   // A fetch wait holds IF/DEC but keeps prefetching up to the outstanding cap;
   // only memory and load-use stalls stop new requests.
   assign imem_re_o = ~reset_i & ~(mem_wait | hazard_i) & fetch_free & ~redirect_i;

   for (genvar gi = 0; gi < NB_STAGES; gi++) begin : g_stage
      assign stall_o[gi] = ~reset_i &
         (mem_wait ? (gi <= MEM_STAGE)
                   : (~redirect_i & (fetch_wait | hazard_i) & (gi <= STG_DEC)));
      assign flush_o[gi] = ~reset_i &
         (mem_wait   ? (gi == MEM_STAGE + 1) :
          redirect_i ? (gi < EXEC_STAGE)
                     : (~fetch_wait & hazard_i & (gi == EXEC_STAGE)));
   end

   rv32i_fetch_tracker #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_fetch_tracker (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .issue_i     (imem_re_o),
      .imem_valid_i(imem_valid_i),
      .redirect_i  (redirect_acc),
      .busy_o      (fetch_busy),
      .free_o      (fetch_free),
      .inst_kill_o (inst_kill_o)
   );

`ifdef RV32I_PIPELINE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + CNT_W'(stall_o[STG_IF]);
      flush_cycles_d = flush_cycles_q + CNT_W'(inst_kill_o);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stall_cycles_q <= '0;
         flush_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_cycles_q <= flush_cycles_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_cycles_o = flush_cycles_q;
`endif

endmodule

// File: tb/tb_rv32i_pipeline_ctrl.sv
// Self-checking bench for rv32i_pipeline_ctrl (counter checks need RV32I_PIPELINE_CTRL_PERF_EN).
// Row encoding: {rst,hz,dreq,dval,redir,ival}_{re,kill}_{stall[4:0]}_{flush[4:0]}
module tb_rv32i_pipeline_ctrl;

   localparam int TB_CNT_W = 3;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       imem_re_o;
   logic       imem_valid_i;
   logic       inst_kill_o;
   logic       hazard_i;
   logic       dmem_req_i;
   logic       dmem_valid_i;
   logic       redirect_i;
   logic [4:0] stall_o;
   logic [4:0] flush_o;
`ifdef RV32I_PIPELINE_CTRL_PERF_EN
   logic [TB_CNT_W-1:0] stall_cycles_o;
   logic [TB_CNT_W-1:0] flush_cycles_o;
`endif

   int checks = 0;
   int errors = 0;
   logic [11:0] sb [$];

   rv32i_pipeline_ctrl #(
      .NB_STAGES(5), .EXEC_STAGE(2), .MEM_STAGE(3), .MAX_OUTSTANDING(2), .CNT_W(TB_CNT_W)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .imem_re_o   (imem_re_o),
      .imem_valid_i(imem_valid_i),
      .inst_kill_o (inst_kill_o),
      .hazard_i    (hazard_i),
      .dmem_req_i  (dmem_req_i),
      .dmem_valid_i(dmem_valid_i),
      .redirect_i  (redirect_i),
      .stall_o     (stall_o),
      .flush_o     (flush_o)
`ifdef RV32I_PIPELINE_CTRL_PERF_EN
      ,
      .stall_cycles_o(stall_cycles_o),
      .flush_cycles_o(flush_cycles_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic drive_row(input logic [17:0] r);
      reset_i      = r[17];
      hazard_i     = r[16];
      dmem_req_i   = r[15];
      dmem_valid_i = r[14];
      redirect_i   = r[13];
      imem_valid_i = r[12];
      sb.push_back(r[11:0]);
   endtask

   task automatic run_table(input string name, input logic [17:0] tbl [$]);
      logic [11:0] exp;
      foreach (tbl[i]) begin
         drive_row(tbl[i]);
         #2;
         exp = sb.pop_front();
         checks += 4;
         if (imem_re_o !== exp[11]) begin
            errors++;
            $display("FAIL %s[%0d] imem_re_o: got %b expected %b", name, i, imem_re_o, exp[11]);
         end
         if (inst_kill_o !== exp[10]) begin
            errors++;
            $display("FAIL %s[%0d] inst_kill_o: got %b expected %b", name, i, inst_kill_o, exp[10]);
         end
         if (stall_o !== exp[9:5]) begin
            errors++;
            $display("FAIL %s[%0d] stall_o: got %b expected %b", name, i, stall_o, exp[9:5]);
         end
         if (flush_o !== exp[4:0]) begin
            errors++;
            $display("FAIL %s[%0d] flush_o: got %b expected %b", name, i, flush_o, exp[4:0]);
         end
         $display("%s[%0d]: re=%b kill=%b stall=%b flush=%b", name, i, imem_re_o, inst_kill_o, stall_o, flush_o);
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [17:0] tbl [$] = '{
         18'b111111_00_00000_00000,
         18'b100000_00_00000_00000
      };
      run_table("reset", tbl);
   endtask

   // Outstanding cap: two issues, then no request until a response arrives.
   task automatic test_fetch_limit();
      logic [17:0] tbl [$] = '{
         18'b000000_10_00000_00000,
         18'b000000_10_00011_00000,
         18'b000000_00_00011_00000,
         18'b000000_00_00011_00000,
         18'b000001_10_00000_00000
      };
      run_table("fetch_limit", tbl);
   endtask

   // Two wrong-path fetches in flight at the redirect: exactly two kills.
   task automatic test_redirect_kill();
      logic [17:0] tbl [$] = '{
         18'b000010_00_00000_00011,
         18'b000000_00_00011_00000,
         18'b000001_11_00000_00000,
         18'b000001_11_00000_00000,
         18'b000001_10_00000_00000,
         18'b000001_10_00000_00000
      };
      run_table("redirect_kill", tbl);
   endtask

   // Redirect held during dmem wait, accepted with dmem_valid, then re-redirect in FLUSH.
   task automatic test_mem_wait();
      logic [17:0] tbl [$] = '{
         18'b001010_00_01111_10000,
         18'b001010_00_01111_10000,
         18'b001010_00_01111_10000,
         18'b001110_00_00000_00011,
         18'b000001_11_00000_00000,
         18'b000011_01_00000_00011,
         18'b000001_11_00000_00000,
         18'b000001_10_00000_00000
      };
      run_table("mem_wait", tbl);
   endtask

   task automatic test_hazard();
      logic [17:0] tbl [$] = '{
         18'b010001_00_00011_00100,
         18'b010010_00_00000_00011,
         18'b010000_00_00011_00100,
         18'b000000_10_00000_00000
      };
      run_table("hazard", tbl);
   endtask

   // Reset mid-FLUSH, then a stray response with nothing outstanding.
   task automatic test_reset_flush();
      logic [17:0] tbl [$] = '{
         18'b000000_10_00011_00000,
         18'b000010_00_00000_00011,
         18'b110001_00_00000_00000,
         18'b000000_10_00000_00000,
         18'b100000_00_00000_00000,
         18'b000001_11_00000_00000,
         18'b000000_10_00000_00000
      };
      run_table("reset_flush", tbl);
   endtask

`ifdef RV32I_PIPELINE_CTRL_PERF_EN
   task automatic test_perf();
      logic [17:0] tbl_a [$] = '{
         18'b100000_00_00000_00000,
         18'b000000_10_00000_00000,
         18'b000000_10_00011_00000,
         18'b000010_00_00000_00011,
         18'b000000_00_00011_00000,
         18'b000001_11_00000_00000,
         18'b000001_11_00000_00000,
         18'b010001_00_00011_00100,
         18'b010001_00_00011_00100
      };
      logic [17:0] tbl_b [$] = '{
         18'b010000_00_00011_00100,
         18'b010000_00_00011_00100,
         18'b010000_00_00011_00100,
         18'b010000_00_00011_00100
      };
      run_table("perf_a", tbl_a);
      checks += 2;
      if (stall_cycles_o !== TB_CNT_W'(4)) begin
         errors++;
         $display("FAIL perf stall_cycles_o: got %0d expected 4", stall_cycles_o);
      end
      if (flush_cycles_o !== TB_CNT_W'(2)) begin
         errors++;
         $display("FAIL perf flush_cycles_o: got %0d expected 2", flush_cycles_o);
      end
      run_table("perf_b", tbl_b);
      checks += 2;
      if (stall_cycles_o !== TB_CNT_W'(0)) begin
         errors++;
         $display("FAIL perf_wrap stall_cycles_o: got %0d expected 0", stall_cycles_o);
      end
      if (flush_cycles_o !== TB_CNT_W'(2)) begin
         errors++;
         $display("FAIL perf_wrap flush_cycles_o: got %0d expected 2", flush_cycles_o);
      end
   endtask
`endif

   initial begin
      reset_i      = 1'b1;
      hazard_i     = 1'b0;
      dmem_req_i   = 1'b0;
      dmem_valid_i = 1'b0;
      redirect_i   = 1'b0;
      imem_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      test_reset();
      test_fetch_limit();
      test_redirect_kill();
      test_mem_wait();
      test_hazard();
      test_reset_flush();
`ifdef RV32I_PIPELINE_CTRL_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
